serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 11 +
 rtl/serial_subtractor_full_subtractor.sv | 18 +
 rtl/serial_subtractor.sv | 118 +++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
//   sub_state_t : FSM state encoding (IDLE, RUN, DONE)
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: diff = a - b - bin.
//   a, b : operand bits
//   bin  : incoming borrow
//   diff : difference bit
//   bout : outgoing borrow
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // Borrow when b exceeds a, or when they are equal and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
//   clk, reset       : clock and synchronous active-high reset
//   start, a, b      : start request and operands, sampled in IDLE
//   busy             : high while bits are being processed
//   done             : one-cycle pulse when results are updated
//   diff             : a - b modulo 2^WIDTH
//   borrow_out       : unsigned a < b
//   zero             : diff == 0
//   ovf              : signed overflow of a - b
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CNT_W-1:0] cnt;
  logic             bw;
  logic             a_msb;
  logic             b_msb;

  logic             cell_d;
  logic             cell_b;
  logic [WIDTH-1:0] res_next;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bw),
    .diff (cell_d),
    .bout (cell_b)
  );

  // Result register shifts right with the new bit entering at the MSB.
  assign res_next = (res_sr >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

  // FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      bw         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b1;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            res_sr <= '0;
            cnt   <= '0;
            bw    <= 1'b0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res_sr <= res_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          bw     <= cell_b;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            // The final bit's difference is the result MSB used for overflow.
            diff       <= res_next;
            borrow_out <= cell_b;
            zero       <= (res_next == '0);
            ovf        <= (a_msb ^ b_msb) & (a_msb ^ cell_d);
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
